// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and data access.
// Optional watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst,
  // fetch side
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic          if_valid,
  output logic [DW-1:0] if_rdata,
  output logic          if_stall,
  // data side
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_valid,
  output logic [DW-1:0] d_rdata,
  output logic          d_stall,
  // memory side
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          mem_err,
  // debug
  output logic [1:0]    dbg_state
);

  // Handshake: a requester raises req with stable addr/data and holds them until
  // its valid pulses; valid is a single-cycle completion, sampled on that edge.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          drop, drop_nxt;
  logic          drop_now;
  logic [AW-1:0] addr_q, addr_nxt;
  logic [DW-1:0] wdata_q, wdata_nxt;
  logic          we_q, we_nxt;
  logic          busy;
  logic          done;
  logic          timeout_hit;
  logic          grant_i, grant_d;

  assign busy     = (state != IDLE);
  assign done     = busy & (mem_ready | timeout_hit);
  assign drop_now = (state == I_BUSY) & (drop | if_flush);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      drop    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state   <= state_nxt;
      drop    <= drop_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
      we_q    <= we_nxt;
    end
  end

  always_comb begin
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    state_nxt = state;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    we_nxt    = we_q;
    drop_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (d_req)       grant_d = 1'b1;
        else if (if_req) grant_i = 1'b1;
      end
      I_BUSY: begin
        // A completed fetch is not re-granted on its own edge; only a dropped
        // one is, so the redirected PC is fetched with no idle cycle.
        if (done) begin
          if (d_req)                  grant_d = 1'b1;
          else if (if_req && drop_now) grant_i = 1'b1;
        end else begin
          drop_nxt = drop_now;
        end
      end
      D_BUSY: begin
        if (done && if_req) grant_i = 1'b1;
      end
      default: ;
    endcase

    if (grant_d) begin
      state_nxt = D_BUSY;
      addr_nxt  = d_addr;
      wdata_nxt = d_wdata;
      we_nxt    = d_we;
    end else if (grant_i) begin
      state_nxt = I_BUSY;
      addr_nxt  = if_addr;
      wdata_nxt = '0;
      we_nxt    = 1'b0;
    end else if (done) begin
      state_nxt = IDLE;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt;

  // The cycle that would make the count reach the limit force-completes the access.
  assign timeout_hit = busy & ~mem_ready & (to_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt  <= '0;
      mem_err <= 1'b0;
    end else begin
      if (grant_i || grant_d)  to_cnt <= '0;
      else if (busy && !done)  to_cnt <= to_cnt + 1'b1;
      if (timeout_hit)         mem_err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign mem_err     = 1'b0;
`endif

  assign mem_req   = busy;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign if_valid = (state == I_BUSY) & done & ~drop_now;
  assign d_valid  = (state == D_BUSY) & done;
  assign if_rdata = timeout_hit ? '0 : mem_rdata;
  assign d_rdata  = timeout_hit ? '0 : mem_rdata;
  assign if_stall = if_req & ~if_valid;
  assign d_stall  = d_req & ~d_valid;

  assign dbg_state = state;

  // Memory-side request must hold steady until the access completes.
  a_mem_stable: assert property (@(posedge clk) disable iff (rst)
    (mem_req && !done) |=> (mem_req && $stable(mem_addr) && $stable(mem_we) && $stable(mem_wdata)));

  a_one_valid: assert property (@(posedge clk) disable iff (rst) !(if_valid && d_valid));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter with a word-level memory reference model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, if_valid, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_valid, d_stall;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_ready, mem_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] dev   [32];
  logic [31:0] ref_m [32];
  logic [31:0] d_exp_q[$];
  logic [31:0] i_exp_q[$];

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_valid(if_valid), .if_rdata(if_rdata), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(d_valid), .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_err(mem_err),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    logic        d_done, i_done, in_acc, held;
    int          wait_left, idx;
    logic [31:0] h_addr, h_wdata;
    logic        h_we;

    rst = 1'b1; if_req = 0; if_addr = 0; if_flush = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    mem_ready = 0; mem_rdata = 0;
    for (int i = 0; i < 32; i++) begin
      dev[i]   = $urandom;
      ref_m[i] = dev[i];
    end

    // ---- reset state
    repeat (3) @(posedge clk);
    smp();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_d_valid", d_valid, 0);
    chk("rst_mem_err", mem_err, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    tick(); rst = 1'b0;

    // ---- fetch only, zero-wait memory
    tick();
    if_req = 1; if_addr = 32'h100; mem_ready = 1; mem_rdata = 32'hDEADBEEF;
    smp();
    chk("f0_mem_req", mem_req, 0);
    chk("f0_if_stall", if_stall, 1);
    tick(); smp();
    chk("f1_mem_req", mem_req, 1);
    chk("f1_mem_addr", mem_addr, 32'h100);
    chk("f1_if_valid", if_valid, 1);
    chk("f1_if_rdata", if_rdata, 32'hDEADBEEF);
    chk("f1_if_stall", if_stall, 0);
    tick(); if_req = 0; smp();
    chk("f2_mem_req", mem_req, 0);
    chk("f2_if_valid", if_valid, 0);

    // ---- contention: data first, then fetch with no idle cycle
    tick();
    if_req = 1; if_addr = 32'h104; d_req = 1; d_we = 0; d_addr = 32'h2000;
    mem_ready = 1; mem_rdata = 32'h1111_2222;
    smp();
    chk("c0_d_stall", d_stall, 1);
    chk("c0_if_stall", if_stall, 1);
    tick(); smp();
    chk("c1_mem_addr", mem_addr, 32'h2000);
    chk("c1_mem_we", mem_we, 0);
    chk("c1_d_valid", d_valid, 1);
    chk("c1_d_rdata", d_rdata, 32'h1111_2222);
    chk("c1_d_stall", d_stall, 0);
    chk("c1_if_stall", if_stall, 1);
    tick(); d_req = 0; mem_rdata = 32'h3333_4444; smp();
    chk("c2_mem_addr", mem_addr, 32'h104);
    chk("c2_if_valid", if_valid, 1);
    chk("c2_if_rdata", if_rdata, 32'h3333_4444);
    chk("c2_if_stall", if_stall, 0);
    chk("c2_d_valid", d_valid, 0);
    tick(); if_req = 0; smp();
    chk("c3_mem_req", mem_req, 0);

    // ---- store with three wait states
    tick();
    d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'h55; mem_ready = 0;
    smp();
    chk("w0_mem_req", mem_req, 0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 4) mem_ready = 1;
      smp();
      chk($sformatf("w%0d_mem_req", i), mem_req, 1);
      chk($sformatf("w%0d_mem_we", i), mem_we, 1);
      chk($sformatf("w%0d_mem_addr", i), mem_addr, 32'h40);
      chk($sformatf("w%0d_mem_wdata", i), mem_wdata, 32'h55);
      chk($sformatf("w%0d_d_valid", i), d_valid, (i == 4) ? 32'd1 : 32'd0);
    end
    tick(); d_req = 0; mem_ready = 0; smp();
    chk("w5_mem_req", mem_req, 0);
    chk("w5_d_valid", d_valid, 0);

    // ---- flush in flight, redirected fetch follows immediately
    tick(); if_req = 1; if_addr = 32'h200; mem_ready = 0;
    tick(); if_flush = 1; smp();
    chk("fl1_mem_addr", mem_addr, 32'h200);
    chk("fl1_if_valid", if_valid, 0);
    tick(); if_flush = 0; if_addr = 32'h300; smp();
    chk("fl2_if_valid", if_valid, 0);
    tick(); mem_ready = 1; mem_rdata = 32'hAAAA_0200; smp();
    chk("fl3_mem_addr", mem_addr, 32'h200);
    chk("fl3_if_valid", if_valid, 0);
    chk("fl3_if_stall", if_stall, 1);
    tick(); mem_rdata = 32'hBBBB_0300; smp();
    chk("fl4_mem_addr", mem_addr, 32'h300);
    chk("fl4_if_valid", if_valid, 1);
    chk("fl4_if_rdata", if_rdata, 32'hBBBB_0300);
    tick(); if_req = 0; mem_ready = 0; smp();
    chk("fl5_mem_req", mem_req, 0);

`ifdef MEM_ARB_TIMEOUT_EN
    // ---- watchdog force-completes a hung load
    tick();
    d_req = 1; d_we = 0; d_addr = 32'h44; mem_ready = 0; mem_rdata = 32'hFFFF_FFFF;
    for (int i = 1; i <= 4; i++) begin
      tick(); smp();
      chk($sformatf("t%0d_d_valid", i), d_valid, (i == 4) ? 32'd1 : 32'd0);
      chk($sformatf("t%0d_mem_err", i), mem_err, 0);
      if (i == 4) chk("t4_d_rdata", d_rdata, 0);
    end
    tick(); d_req = 0; smp();
    chk("t5_mem_err", mem_err, 1);
    chk("t5_mem_req", mem_req, 0);
    tick(); if_req = 1; if_addr = 32'h108; mem_ready = 1; mem_rdata = 32'hCAFE_F00D;
    tick(); smp();
    chk("t6_if_valid", if_valid, 1);
    chk("t6_if_rdata", if_rdata, 32'hCAFE_F00D);
    chk("t6_mem_err", mem_err, 1);
    tick(); if_req = 0; mem_ready = 0;
`endif

    // ---- reset in the middle of a store
    tick(); d_req = 1; d_we = 1; d_addr = 32'h80; d_wdata = 32'h77; mem_ready = 0;
    tick(); smp();
    chk("r1_mem_req", mem_req, 1);
    tick(); #2;
    rst = 1; mem_ready = 1;
    #1;
    chk("r_mem_req", mem_req, 0);
    chk("r_d_valid", d_valid, 0);
    chk("r_mem_addr", mem_addr, 0);
    chk("r_mem_we", mem_we, 0);
    chk("r_mem_err", mem_err, 0);
    d_req = 0;
    tick(); smp();
    chk("r2_mem_req", mem_req, 0);
    tick(); rst = 0; mem_ready = 0;

    // ---- randomized traffic against the reference memory
    d_done = 0; i_done = 0; in_acc = 0; held = 0; wait_left = 0;
    h_addr = 0; h_wdata = 0; h_we = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (d_req && d_done) begin
        d_req = 0; d_done = 0;
      end else if (!d_req && c < 2900 && $urandom_range(0, 3) == 0) begin
        idx = 16 + $urandom_range(0, 15);
        d_req = 1; d_we = $urandom_range(0, 1); d_addr = 32'(idx) << 2; d_wdata = $urandom;
        if (!d_we) d_exp_q.push_back(ref_m[idx]);
      end
      if (if_req && i_done) begin
        if_req = 0; i_done = 0;
      end else if (!if_req && c < 2900 && $urandom_range(0, 2) == 0) begin
        idx = $urandom_range(0, 15);
        if_req = 1; if_addr = 32'(idx) << 2;
        i_exp_q.push_back(ref_m[idx]);
      end
      if (mem_req) begin
        if (!in_acc) begin
          in_acc = 1; wait_left = $urandom_range(0, 2);
        end
        mem_ready = (wait_left == 0);
        if (wait_left != 0) wait_left--;
      end else begin
        mem_ready = $urandom_range(0, 1);
      end
      mem_rdata = (mem_req && mem_ready) ? dev[mem_addr[6:2]] : $urandom;

      smp();
      if (d_valid) begin
        chk("rnd_d_valid_req", d_req, 1);
        if (d_we) ref_m[d_addr[6:2]] = d_wdata;
        else if (d_exp_q.size() != 0) chk("rnd_d_load", d_rdata, d_exp_q.pop_front());
        d_done = 1;
      end
      if (if_valid) begin
        chk("rnd_if_valid_req", if_req, 1);
        if (i_exp_q.size() != 0) chk("rnd_fetch", if_rdata, i_exp_q.pop_front());
        i_done = 1;
      end
      if (mem_req) begin
        if (held) begin
          chk("rnd_hold_addr", mem_addr, h_addr);
          chk("rnd_hold_we", mem_we, h_we);
          chk("rnd_hold_wdata", mem_wdata, h_wdata);
        end else begin
          held = 1; h_addr = mem_addr; h_we = mem_we; h_wdata = mem_wdata;
        end
        if (mem_ready) begin
          if (mem_we) dev[mem_addr[6:2]] = mem_wdata;
          in_acc = 0; held = 0;
        end
      end
    end

    // Every issued load was answered and the stores landed where the loads saw them.
    chk("end_d_req", d_req, 0);
    chk("end_if_req", if_req, 0);
    chk("end_d_q", d_exp_q.size(), 0);
    chk("end_i_q", i_exp_q.size(), 0);
    chk("end_mem_err", mem_err, 0);
    for (int i = 16; i < 32; i++) chk($sformatf("end_mem_%0d", i), dev[i], ref_m[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
